// File: rtl/btn_reset_pkg.sv
// ============================================================================
// Module      : btn_reset_pkg
// Description : Shared types and sizing helper for the reset/button block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package btn_reset_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_POR       = 2'd1,
        S_RUN       = 2'd2,
        S_BTN_HOLD  = 2'd3
    } rst_state_t;

    // Bits needed for a counter that must hold value-1; never narrower than one bit.
    function automatic int cnt_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : One button channel: 2-FF synchroniser, polarity fix-up,
//               debounce counter, press/release pulses and, when
//               BTN_LONG_PRESS_EN is defined, a single long-press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import btn_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter bit ACTIVE_LOW        = 1'b0
`ifdef BTN_LONG_PRESS_EN
    , parameter int LONG_PRESS_CYCLES = 25000000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    localparam int              DB_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync_meta;
    logic            r_sync;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            r_press;
    logic            r_release;

    logic            w_sample;
    logic            w_differs;
    logic            w_flip;

    assign w_sample  = r_sync ^ ACTIVE_LOW;
    assign w_differs = (w_sample != r_level);
    assign w_flip    = w_differs && (r_db_cnt == c_DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_db_cnt    <= '0;
            r_level     <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_sync_meta <= i_btn;
            r_sync      <= r_sync_meta;
            r_press     <= w_flip && !r_level;
            r_release   <= w_flip && r_level;
            if (w_flip) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else if (!w_differs) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt != c_DB_LAST) begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

`ifdef BTN_LONG_PRESS_EN
    localparam int              LP_W      = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LP_W-1:0] c_LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0] r_hold_cnt;
    logic            r_long_done;
    logic            r_long;

    // Hold counter saturates; r_long_done blocks a repeat until the button is released.
    always_ff @(posedge clk) begin
        if (rst || !r_level) begin
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_long      <= (r_hold_cnt == c_LP_LAST) && !r_long_done;
            r_long_done <= r_long_done || (r_hold_cnt == c_LP_LAST);
            if (r_hold_cnt != c_LP_LAST) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign o_long = r_long;
`else
    assign o_long = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/btn_reset_ctrl.sv
// ============================================================================
// Module      : btn_reset_ctrl
// Description : Power-on / PLL-lock reset sequencer plus NB_BTN debounced
//               button channels with press/release (and optional long-press)
//               events. Optional feature macro: BTN_LONG_PRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_reset_ctrl
    import btn_reset_pkg::*;
#(
    parameter int                NB_BTN          = 7,
    parameter logic [NB_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
    parameter int                RESET_BTN       = 0,
    parameter int                DEBOUNCE_CYCLES = 250000,
    parameter int                POR_CYCLES      = 31
`ifdef BTN_LONG_PRESS_EN
    , parameter int              LONG_PRESS_CYCLES = 25000000
`endif
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              pll_locked_i,
    input  logic [NB_BTN-1:0] btn_i,
    output logic [NB_BTN-1:0] btn_level_o,
    output logic [NB_BTN-1:0] btn_press_o,
    output logic [NB_BTN-1:0] btn_release_o,
    output logic [NB_BTN-1:0] btn_long_o,
    output logic              reset_o
);

    localparam int               POR_W       = cnt_width(POR_CYCLES);
    // The cycle in which the trigger is first seen counts as the first hold
    // cycle, so S_POR itself lasts POR_CYCLES-1 cycles (skipped when that is 0).
    localparam logic [POR_W-1:0] c_POR_LAST  = POR_W'((POR_CYCLES > 1) ? POR_CYCLES - 2 : 0);
    localparam rst_state_t       c_POR_ENTRY = (POR_CYCLES > 1) ? S_POR : S_RUN;

    logic             r_lock_meta;
    logic             r_lock_sync;
    rst_state_t       r_state;
    rst_state_t       w_state_next;
    logic [POR_W-1:0] r_por_cnt;
    logic             r_reset;
    logic             w_reset_next;
    logic             w_rst_btn;

    for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .ACTIVE_LOW        (ACTIVE_LOW_MASK[gi])
`ifdef BTN_LONG_PRESS_EN
            , .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
`endif
        ) u_debounce (
            .clk       (clk),
            .rst       (reset_i),
            .i_btn     (btn_i[gi]),
            .o_level   (btn_level_o[gi]),
            .o_press   (btn_press_o[gi]),
            .o_release (btn_release_o[gi]),
            .o_long    (btn_long_o[gi])
        );
    end

    assign w_rst_btn = btn_level_o[RESET_BTN];

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_state     <= S_WAIT_LOCK;
            r_por_cnt   <= '0;
            r_reset     <= 1'b1;
        end else begin
            r_lock_meta <= pll_locked_i;
            r_lock_sync <= r_lock_meta;
            r_state     <= w_state_next;
            r_reset     <= w_reset_next;
            if ((r_state == S_POR) && (w_state_next == S_POR)) begin
                r_por_cnt <= r_por_cnt + 1'b1;
            end else begin
                r_por_cnt <= '0;
            end
        end
    end

    // Loss of lock overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        if (!r_lock_sync) begin
            w_state_next = S_WAIT_LOCK;
        end else begin
            case (r_state)
                S_WAIT_LOCK: w_state_next = c_POR_ENTRY;
                S_POR:       if (r_por_cnt == c_POR_LAST) w_state_next = S_RUN;
                S_RUN:       if (w_rst_btn) w_state_next = S_BTN_HOLD;
                S_BTN_HOLD:  if (!w_rst_btn) w_state_next = c_POR_ENTRY;
                default:     w_state_next = S_WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        w_reset_next = (w_state_next != S_RUN);
    end

    assign reset_o = r_reset;

endmodule

`default_nettype wire

// File: tb/tb_btn_reset_ctrl.sv
// ============================================================================
// Module      : tb_btn_reset_ctrl
// Description : Self-checking bench for btn_reset_ctrl with a cycle-level
//               behavioural reference model (timestamps and run lengths).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_reset_ctrl;

    localparam int            NB   = 2;
    localparam logic [NB-1:0] MASK = 2'b01;
    localparam int            RB   = 0;
    localparam int            DEB  = 4;
    localparam int            POR  = 8;
    localparam int            LONG = 20;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          pll_locked_i = 1'b0;
    logic [NB-1:0] btn_i;
    logic [NB-1:0] btn_level_o;
    logic [NB-1:0] btn_press_o;
    logic [NB-1:0] btn_release_o;
    logic [NB-1:0] btn_long_o;
    logic          reset_o;

    logic [NB-1:0] idle_v = MASK;

    always #5 clk = ~clk;

    btn_reset_ctrl #(
        .NB_BTN          (NB),
        .ACTIVE_LOW_MASK (MASK),
        .RESET_BTN       (RB),
        .DEBOUNCE_CYCLES (DEB),
        .POR_CYCLES      (POR)
`ifdef BTN_LONG_PRESS_EN
        , .LONG_PRESS_CYCLES (LONG)
`endif
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .pll_locked_i  (pll_locked_i),
        .btn_i         (btn_i),
        .btn_level_o   (btn_level_o),
        .btn_press_o   (btn_press_o),
        .btn_release_o (btn_release_o),
        .btn_long_o    (btn_long_o),
        .reset_o       (reset_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    logic [NB-1:0] m_pipe0 = '0, m_pipe1 = '0, m_lvl = '0;
    logic [NB-1:0] m_press = '0, m_rel = '0, m_long = '0;
    int            m_diff[NB];
    int            m_hrun[NB];
    logic          m_lk0 = 1'b0, m_lk1 = 1'b0;
    bit            m_running = 1'b0;
    bit            m_holding = 1'b0;
    int            m_due = -1;

    // Advance the model by one clock edge; cyc is the cycle that edge starts.
    task automatic model_step();
        logic samp;
        // Reset sequencer: reset_o is low from the cycle POR after the trigger cycle.
        if (reset_i || !m_lk1) begin
            m_running = 1'b0;
            m_holding = 1'b0;
            m_due     = -1;
        end else if (m_running) begin
            if (m_lvl[RB]) begin
                m_running = 1'b0;
                m_holding = 1'b1;
            end
        end else if (m_holding) begin
            if (!m_lvl[RB]) begin
                m_holding = 1'b0;
                m_due     = cyc - 1 + POR;
            end
        end else if (m_due < 0) begin
            m_due = cyc - 1 + POR;
        end
        if (!m_running && !m_holding && (m_due >= 0) && (cyc >= m_due)) begin
            m_running = 1'b1;
            m_due     = -1;
        end

        if (reset_i) begin
            m_lk1 = 1'b0;
            m_lk0 = 1'b0;
        end else begin
            m_lk1 = m_lk0;
            m_lk0 = pll_locked_i;
        end

        // Buttons: level flips after DEB consecutive samples disagreeing with it.
        for (int i = 0; i < NB; i++) begin
            m_press[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_long[i]  = 1'b0;
            if (reset_i) begin
                m_pipe0[i] = 1'b0;
                m_pipe1[i] = 1'b0;
                m_lvl[i]   = 1'b0;
                m_diff[i]  = 0;
                m_hrun[i]  = 0;
            end else begin
                samp       = m_pipe1[i] ^ idle_v[i];
                m_pipe1[i] = m_pipe0[i];
                m_pipe0[i] = btn_i[i];
`ifdef BTN_LONG_PRESS_EN
                m_long[i]  = (m_hrun[i] == LONG);
`endif
                if (samp == m_lvl[i]) m_diff[i] = 0;
                else                  m_diff[i] = m_diff[i] + 1;
                if (m_diff[i] == DEB) begin
                    m_lvl[i]  = ~m_lvl[i];
                    m_diff[i] = 0;
                    if (m_lvl[i]) m_press[i] = 1'b1;
                    else          m_rel[i]   = 1'b1;
                end
                if (!m_lvl[i])              m_hrun[i] = 0;
                else if (m_hrun[i] <= LONG) m_hrun[i] = m_hrun[i] + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_val("reset_o",     32'(reset_o),       32'(!m_running));
        check_val("btn_level",   32'(btn_level_o),   32'(m_lvl));
        check_val("btn_press",   32'(btn_press_o),   32'(m_press));
        check_val("btn_release", 32'(btn_release_o), 32'(m_rel));
        check_val("btn_long",    32'(btn_long_o),    32'(m_long));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int lat, cnt, hi, k_lvl, k_rst, pp, lp;
        for (int i = 0; i < NB; i++) begin
            m_diff[i] = 0;
            m_hrun[i] = 0;
        end
        btn_i        = idle_v;
        reset_i      = 1'b1;
        pll_locked_i = 1'b1;
        run(3);
        check_val("reset_in_reset", 32'(reset_o), 32'd1);

        // Power-on: 2 sync cycles then POR cycles before release
        reset_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lat < 0 && reset_o == 1'b0) lat = k;
        end
        check_val("por_latency", lat, 32'd10);

        // Clean press on channel 1
        btn_i[1] = ~idle_v[1];
        lat = -1; cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (lat < 0 && btn_level_o[1]) lat = k;
            cnt += int'(btn_press_o[1]);
        end
        check_val("press_latency", lat, 32'd6);
        check_val("press_count", cnt, 32'd1);
        btn_i[1] = idle_v[1];
        run(12);

        // 3-cycle glitch is rejected
        btn_i[1] = ~idle_v[1];
        cnt = 0; hi = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 4) btn_i[1] = idle_v[1];
            step();
            cnt += int'(btn_press_o[1]);
            hi  += int'(btn_level_o[1]);
        end
        check_val("glitch3_press", cnt, 32'd0);
        check_val("glitch3_level", hi, 32'd0);

        // 4-cycle pulse is just long enough to be accepted
        btn_i[1] = ~idle_v[1];
        cnt = 0;
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) btn_i[1] = idle_v[1];
            step();
            cnt += int'(btn_press_o[1]) + int'(btn_release_o[1]);
        end
        check_val("pulse4_edges", cnt, 32'd2);

        // Active-low manual reset button
        btn_i[0] = ~idle_v[0];
        run(12);
        check_val("btn_hold_reset", 32'(reset_o), 32'd1);
        btn_i[0] = idle_v[0];
        k_lvl = -1; k_rst = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k_lvl < 0 && !btn_level_o[0]) k_lvl = k;
            if (k_lvl >= 0 && k_rst < 0 && !reset_o) k_rst = k;
        end
        check_val("btn_release_por", k_rst - k_lvl, 32'd8);

        // Lock loss, relock, loss mid-POR, relock
        pll_locked_i = 1'b0;
        run(6);
        pll_locked_i = 1'b1;
        run(5);
        pll_locked_i = 1'b0;
        run(4);
        check_val("lock_lost_reset", 32'(reset_o), 32'd1);
        pll_locked_i = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (lat < 0 && reset_o == 1'b0) lat = k;
        end
        check_val("relock_latency", lat, 32'd10);

        // Long press on channel 1 (held 30 cycles)
        btn_i[1] = ~idle_v[1];
        pp = -1; lp = -1; cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 31) btn_i[1] = idle_v[1];
            step();
            if (pp < 0 && btn_press_o[1]) pp = k;
            if (lp < 0 && btn_long_o[1])  lp = k;
            cnt += int'(btn_long_o[1]);
        end
`ifdef BTN_LONG_PRESS_EN
        check_val("long_count", cnt, 32'd1);
        check_val("long_delay", lp - pp, 32'd20);
`else
        check_val("long_count", cnt, 32'd0);
`endif

        // reset_i while pressed: cleared, then a fresh press after 6 cycles
        btn_i[1] = ~idle_v[1];
        run(10);
        reset_i = 1'b1;
        run(2);
        check_val("reset_clears_level", 32'(btn_level_o), 32'd0);
        reset_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (lat < 0 && btn_press_o[1]) lat = k;
        end
        check_val("repress_latency", lat, 32'd6);
        btn_i[1] = idle_v[1];
        run(20);

        // Randomised phase at several toggle rates
        for (int seg = 0; seg < 4; seg++) begin
            int rate;
            rate = (seg == 0) ? 3 : (seg == 1) ? 8 : (seg == 2) ? 40 : 15;
            for (int k = 0; k < 1200; k++) begin
                for (int i = 0; i < NB; i++) begin
                    if ($urandom_range(0, rate - 1) == 0) btn_i[i] = ~btn_i[i];
                end
                if (pll_locked_i) pll_locked_i = ($urandom_range(0, 299) != 0);
                else              pll_locked_i = ($urandom_range(0, 3) == 0);
                reset_i = ($urandom_range(0, 599) == 0);
                step();
            end
        end

        reset_i      = 1'b0;
        pll_locked_i = 1'b1;
        btn_i        = idle_v;
        run(30);
        check_val("final_reset_o", 32'(reset_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
